alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle execute-stage controller that sits directly upstream of, and wraps around, the team's combinational ALU (A, B, 3-bit ALU_OP in; F, ZF, OF out).
- Holds a 32x32 general register file.
- Accepts one register-to-register command at a time, fetches operands, drives the ALU, captures its result and flags, then writes the result back.
- Forms the datapath core of the lab multi-cycle CPU; an instruction decoder issues its commands.

Parameters:
- REG_ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, datapath width; must equal the ALU width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command (IDLE only).
- cmd_op  input  3  ALU operation code, passed to alu_op.
- cmd_rs1  input  REG_ADDR_W  source register for ALU A.
- cmd_rs2  input  REG_ADDR_W  source register for ALU B.
- cmd_rd  input  REG_ADDR_W  destination register.
- ext_we  input  1  external register write (preload/debug).
- ext_waddr  input  REG_ADDR_W  external write address.
- ext_wdata  input  DATA_W  external write data.
- dbg_raddr  input  REG_ADDR_W  debug read address.
- dbg_rdata  output  DATA_W  combinational register read data.
- alu_a  output  DATA_W  registered operand to ALU A.
- alu_b  output  DATA_W  registered operand to ALU B.
- alu_op  output  3  registered opcode to ALU_OP.
- alu_f  input  DATA_W  ALU result F.
- alu_zf  input  1  ALU zero flag.
- alu_of  input  1  ALU overflow flag.
- result  output  DATA_W  last captured ALU result.
- zf  output  1  sticky zero flag of last completed command.
- of  output  1  sticky overflow flag of last completed command.
- done  output  1  one-cycle pulse on write-back.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, independent of clk:
  - state=IDLE; cmd_ready=1.
  - alu_a, alu_b, result = 0; alu_op=3'b000; zf=0; of=0; done=0.
  - All 32 registers = 0.
- A reset asserted mid-command aborts it: no write-back occurs and done does not pulse.
- Register 0 is hardwired to zero. Writes to it (command or external) are discarded; reads return 0.
- FSM states: IDLE -> LOAD -> EXEC -> WB -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge T, latch op, rs1, rs2 and rd into internal command registers, then go to LOAD.
- LOAD (cycle T+1):
  - alu_a <= R[rs1]; alu_b <= R[rs2]; alu_op <= op.
  - Go to EXEC.
- EXEC (cycle T+2):
  - The ALU settles combinationally from the registered operands.
  - At the edge: result <= alu_f; capture alu_zf/alu_of into pending flags.
  - Go to WB.
- WB (cycle T+3):
  - R[rd] <= result (unless rd=0).
  - zf/of <= pending flags.
  - done=1 for this cycle only.
  - Go to IDLE.
- Latency: accept edge to done high is 3 cycles. Maximum throughput is one command per 4 cycles.
- With cmd_valid held continuously, the next command is accepted on the edge closing WB+1 (first IDLE cycle). There is no accept in WB.
- cmd_ready=0 in LOAD, EXEC and WB; cmd_valid is ignored in those states. Command fields need to be stable only in the accept cycle.
- External write:
  - Honoured only in IDLE; ignored in all other states.
  - If ext_we and a command accept occur in the same IDLE cycle, the external write takes effect at that edge. LOAD then reads the updated value (write-before-read).
- Operands are read in LOAD from the register file's current contents. rs1=rs2=rd is legal; the old value is used and the new value is written in WB.
- alu_a, alu_b and alu_op hold their values after WB until the next LOAD.
- All 8 opcodes pass through unmodified. Flags are taken verbatim from the ALU; no flag recomputation is done here.
- zf/of update only in WB and are otherwise held.
- dbg_rdata = R[dbg_raddr] combinationally; it shows 0 for address 0.

Test Plan:
- Reset mid-operation:
  - Stimulus: accept a command, assert rst_n=0 during EXEC.
  - Required: all outputs go to their reset values immediately; destination register stays 0; no done pulse; cmd_ready=1 after release.
- ADD:
  - Stimulus: preload R1=5, R2=3; issue op=3'b100, rs1=1, rs2=2, rd=3.
  - Required: cmd_ready low for 3 cycles; done at T+3; R3=8; result=8; zf=0; of=0.
- SUB equal operands:
  - Stimulus: R4=0x1234, R5=0x1234; issue op=3'b101, rd=6.
  - Required: R6=0; zf=1; of=0.
  - Follow-up: issue op=3'b001 (OR) on R1,R2.
  - Required: R=7; zf returns to 0.
- Overflow plus write to R0:
  - Stimulus: R7=0x7FFFFFFF, R8=1; issue op=3'b100, rd=0.
  - Required: result=0x80000000; of=1; done pulses; dbg read of R0 = 0.
- Back-to-back and external-write blocking:
  - Stimulus: hold cmd_valid high with two commands queued; drive ext_we to R9 during EXEC.
  - Required: second accept exactly 4 cycles after the first; R9 unchanged.
  - Stimulus: drive ext_we in the same IDLE cycle as an accept whose rs1 is the written register.
  - Required: the command uses the new value.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle execute-stage controller wrapped around the
// external combinational ALU. It owns a general-purpose register file. It
// accepts one register-to-register command at a time and steps through
// IDLE -> LOAD -> EXEC -> WB:
//   IDLE  accept a command and honour external register writes.
//   LOAD  fetch operands into the ALU input registers.
//   EXEC  capture the ALU result and flags.
//   WB    write the result back and pulse done.
// Register 0 always reads as zero.

module alu_op_sequencer #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_rs1,
  input  logic [REG_ADDR_W-1:0] cmd_rs2,
  input  logic [REG_ADDR_W-1:0] cmd_rd,

  input  logic                  ext_we,
  input  logic [REG_ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0]     ext_wdata,

  input  logic [REG_ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata,

  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_W-1:0]     alu_f,
  input  logic                  alu_zf,
  input  logic                  alu_of,

  output logic [DATA_W-1:0]     result,
  output logic                  zf,
  output logic                  of,
  output logic                  done
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Sequencer state and latched command fields.
  state_t                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [REG_ADDR_W-1:0]   rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0]   rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;

  // Registered ALU interface and captured outcome.
  logic [DATA_W-1:0]       alu_a_q, alu_a_d;
  logic [DATA_W-1:0]       alu_b_q, alu_b_d;
  logic [2:0]              alu_op_q, alu_op_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic                    pend_zf_q, pend_zf_d;
  logic                    pend_of_q, pend_of_d;
  logic                    zf_q, zf_d;
  logic                    of_q, of_d;

  // Registered handshake outputs.
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    done_q, done_d;

  // Register file storage.
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];

  // Operand read ports used in LOAD.
  logic [DATA_W-1:0]       rs1_data;
  logic [DATA_W-1:0]       rs2_data;

  logic                    accept;

  assign accept   = cmd_valid && cmd_ready_q;

  assign rs1_data = regs_q[rs1_q];
  assign rs2_data = regs_q[rs2_q];

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign result    = result_q;
  assign zf        = zf_q;
  assign of        = of_q;

  // Next-state and registered-output logic for the four-phase sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    result_d    = result_q;
    pend_zf_d   = pend_zf_q;
    pend_of_d   = pend_of_q;
    zf_d        = zf_q;
    of_d        = of_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d        = cmd_op;
          rs1_d       = cmd_rs1;
          rs2_d       = cmd_rs2;
          rd_d        = cmd_rd;
          cmd_ready_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        alu_a_d  = rs1_data;
        alu_b_d  = rs2_data;
        alu_op_d = op_q;
        state_d  = EXEC;
      end
      EXEC: begin
        result_d  = alu_f;
        pend_zf_d = alu_zf;
        pend_of_d = alu_of;
        done_d    = 1'b1;
        state_d   = WB;
      end
      WB: begin
        zf_d        = pend_zf_q;
        of_d        = pend_of_q;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // Control, ALU-interface and status flops; reset aborts any command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'b000;
      result_q    <= '0;
      pend_zf_q   <= 1'b0;
      pend_of_q   <= 1'b0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      pend_zf_q   <= pend_zf_d;
      pend_of_q   <= pend_of_d;
      zf_q        <= zf_d;
      of_q        <= of_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
    end
  end

  // Register file updates: external writes only while idle, write-back in WB,
  // and entry 0 forced to zero so it never holds a value.
  always_comb begin
    regs_d = regs_q;
    if ((state_q == IDLE) && ext_we) begin
      regs_d[ext_waddr] = ext_wdata;
    end
    if (state_q == WB) begin
      regs_d[rd_q] = result_q;
    end
    regs_d[0] = '0;
  end

  // Register file storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer.
// The bench supplies the combinational ALU around the sequencer. It keeps a
// command-level reference model of the register file and pipeline timing.
// Every cycle it compares the DUT against that model. Directed scenarios add
// hand-computed literal expectations.

module tb_alu_op_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic          ext_we;
  logic [AW-1:0] ext_waddr;
  logic [DW-1:0] ext_wdata;
  logic [AW-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;
  logic [DW-1:0] alu_a, alu_b, alu_f;
  logic [2:0]    alu_op;
  logic          alu_zf, alu_of;
  logic [DW-1:0] result;
  logic          zf, of, done;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.REG_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
    .result(result), .zf(zf), .of(of), .done(done)
  );

  // Lab ALU: returns {of, zf, f}.
  function automatic logic [33:0] alu_fn(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] f;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      3'b000: f = a & b;
      3'b001: f = a | b;
      3'b010: f = a ^ b;
      3'b011: f = ~(a | b);
      3'b100: begin
        f   = a + b;
        ovf = (a[31] == b[31]) && (f[31] != a[31]);
      end
      3'b101: begin
        f   = a - b;
        ovf = (a[31] != b[31]) && (f[31] != a[31]);
      end
      3'b110: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = a << b[4:0];
    endcase
    return {ovf, (f == 32'd0), f};
  endfunction

  assign {alu_of, alu_zf, alu_f} = alu_fn(alu_op, alu_a, alu_b);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference model: command-level view, cycles_left counts down to free.
  logic [31:0] m_regs [32];
  int          m_left = 0;
  logic [31:0] p_a = '0, p_b = '0, p_f = '0;
  logic [2:0]  p_op = '0;
  logic        p_zf = 1'b0, p_of = 1'b0;
  logic [4:0]  p_rd = '0;
  logic [31:0] e_a = '0, e_b = '0, e_result = '0;
  logic [2:0]  e_op = '0;
  logic        e_zf = 1'b0, e_of = 1'b0;

  initial begin
    logic [33:0] r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_left = 0;
        e_a = '0; e_b = '0; e_op = '0; e_result = '0; e_zf = 0; e_of = 0;
      end else if (m_left == 0) begin
        if (ext_we && ext_waddr != 0) m_regs[ext_waddr] = ext_wdata;
        if (cmd_valid) begin
          p_a  = (cmd_rs1 == 0) ? 32'd0 : m_regs[cmd_rs1];
          p_b  = (cmd_rs2 == 0) ? 32'd0 : m_regs[cmd_rs2];
          p_op = cmd_op;
          p_rd = cmd_rd;
          r    = alu_fn(cmd_op, p_a, p_b);
          {p_of, p_zf, p_f} = r;
          m_left = 3;
        end
      end else begin
        if (m_left == 3) begin
          e_a = p_a; e_b = p_b; e_op = p_op;
        end else if (m_left == 2) begin
          e_result = p_f;
        end else begin
          if (p_rd != 0) m_regs[p_rd] = p_f;
          e_zf = p_zf; e_of = p_of;
        end
        m_left--;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_left == 0});
        checkOutput("done", {31'd0, done}, {31'd0, m_left == 1});
        checkOutput("alu_a", alu_a, e_a);
        checkOutput("alu_b", alu_b, e_b);
        checkOutput("alu_op", {29'd0, alu_op}, {29'd0, e_op});
        checkOutput("result", result, e_result);
        checkOutput("zf", {31'd0, zf}, {31'd0, e_zf});
        checkOutput("of", {31'd0, of}, {31'd0, e_of});
        checkOutput("dbg_rdata", dbg_rdata,
                    (dbg_raddr == 0) ? 32'd0 : m_regs[dbg_raddr]);
      end
    end
  end

  // Drive one cycle of inputs, then return just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    cmd_valid = v; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    ext_we = we; ext_waddr = wa; ext_wdata = wd;
    dbg_raddr = dbg_raddr + 5'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 3'b000, 0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(0, 3'b000, 0, 0, 0, 1, a, d);
  endtask

  task automatic peek(input string name, input logic [4:0] a,
                      input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    checkOutput(name, dbg_rdata, exp);
  endtask

  // Issue one command (optionally with a same-cycle external write), wait
  // for done with a bound, then step into IDLE so write-back is visible.
  task automatic run_cmd(input string name, input logic [2:0] op,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
    int n;
    applyStimulus(1, op, rs1, rs2, rd, we, wa, wd);
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      idle_cycle();
      n++;
    end
    checkOutput({name, "_latency"}, n, 2);
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int  second_at;
    int  n;
    logic saw_done;

    rst_n = 1'b0;
    cmd_valid = 0; cmd_op = 0; cmd_rs1 = 0; cmd_rs2 = 0; cmd_rd = 0;
    ext_we = 0; ext_waddr = 0; ext_wdata = 0; dbg_raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD 5 + 3
    preload(1, 32'd5);
    preload(2, 32'd3);
    run_cmd("add", 3'b100, 1, 2, 3, 0, 0, 32'd0);
    peek("add_r3", 3, 32'd8);
    checkOutput("add_result", result, 32'd8);
    checkOutput("add_zf", {31'd0, zf}, 32'd0);
    checkOutput("add_of", {31'd0, of}, 32'd0);

    // SUB equal operands, then OR clears zf
    preload(4, 32'h1234);
    preload(5, 32'h1234);
    run_cmd("sub", 3'b101, 4, 5, 6, 0, 0, 32'd0);
    peek("sub_r6", 6, 32'd0);
    checkOutput("sub_zf", {31'd0, zf}, 32'd1);
    checkOutput("sub_of", {31'd0, of}, 32'd0);
    run_cmd("or", 3'b001, 1, 2, 12, 0, 0, 32'd0);
    peek("or_r12", 12, 32'd7);
    checkOutput("or_zf", {31'd0, zf}, 32'd0);

    // Overflow with destination R0
    preload(7, 32'h7FFF_FFFF);
    preload(8, 32'd1);
    run_cmd("ovf", 3'b100, 7, 8, 0, 0, 0, 32'd0);
    checkOutput("ovf_result", result, 32'h8000_0000);
    checkOutput("ovf_of", {31'd0, of}, 32'd1);
    checkOutput("ovf_zf", {31'd0, zf}, 32'd0);
    peek("ovf_r0", 0, 32'd0);

    // Remaining opcodes pass straight through
    run_cmd("sll", 3'b111, 1, 2, 17, 0, 0, 32'd0);
    peek("sll_r17", 17, 32'd40);
    run_cmd("slt", 3'b110, 2, 1, 18, 0, 0, 32'd0);
    peek("slt_r18", 18, 32'd1);
    run_cmd("nor", 3'b011, 1, 2, 19, 0, 0, 32'd0);
    peek("nor_r19", 19, 32'hFFFF_FFF8);

    // Back-to-back with cmd_valid held; external write in EXEC is dropped
    preload(9, 32'h99);
    applyStimulus(1, 3'b010, 1, 2, 13, 0, 0, 32'd0);
    second_at = -1;
    for (int i = 1; i <= 8 && second_at < 0; i++) begin
      if (cmd_ready === 1'b1) second_at = i;
      applyStimulus(1, 3'b000, 1, 2, 14, (i == 2), 9, 32'hDEAD);
    end
    checkOutput("b2b_spacing", second_at, 4);
    n = 0;
    idle_cycle();
    while (cmd_ready !== 1'b1 && n < 8) begin
      idle_cycle();
      n++;
    end
    peek("b2b_r13", 13, 32'd6);
    peek("b2b_r14", 14, 32'd1);
    peek("b2b_r9_kept", 9, 32'h99);

    // Same-cycle external write feeds the accepted command
    run_cmd("wbr", 3'b100, 10, 1, 11, 1, 10, 32'h55);
    peek("wbr_r11", 11, 32'h5A);
    peek("wbr_r10", 10, 32'h55);

    // rs1 = rs2 = rd uses the old value
    preload(15, 32'd6);
    run_cmd("alias", 3'b100, 15, 15, 15, 0, 0, 32'd0);
    peek("alias_r15", 15, 32'd12);

    // Reset during EXEC aborts the command
    applyStimulus(1, 3'b100, 1, 2, 16, 0, 0, 32'd0);
    idle_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    peek("rst_r1", 1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      idle_cycle();
    end
    checkOutput("rst_no_done", {31'd0, saw_done}, 32'd0);
    checkOutput("rst_ready_after", {31'd0, cmd_ready}, 32'd1);
    peek("rst_r16", 16, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
